// File: rtl/codificador_8_a_3.sv
// codificador_8_a_3
// 8-to-3 binary encoder with enable. It has a combinational code path and a
// one-cycle registered copy of that path.
//
// Each code bit is the XOR of the four input bits whose index has that bit set.
// A one-hot input produces its index. Any other input produces the XOR of the
// indices of all set bits. This is a parity code, not a priority result.
//
// Ports
//   clk      in   system clock; the registered outputs update on the rising edge
//   rst_n    in   asynchronous active-low reset; clears s_q and onehot_q only
//   en       in   enable; 0 forces s to 0 and onehot to 0
//   e[7:0]   in   input vector; bit i stands for index i
//   s[2:0]   out  combinational code
//   s_q[2:0] out  s registered on the rising clk edge
//   onehot   out  combinational flag: en=1 and exactly one bit of e is set
//   onehot_q out  onehot registered on the rising clk edge
module codificador_8_a_3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] e,
  output logic [2:0] s,
  output logic [2:0] s_q,
  output logic       onehot,
  output logic       onehot_q
);

  logic [2:0] code_d;
  logic [2:0] code_q;
  logic       valid_d;
  logic       valid_q;
  logic [3:0] ones;

  // Code bits. Reset deliberately does not gate this path.
  always_comb begin
    code_d = '0;
    if (en) begin
      code_d[0] = e[1] ^ e[3] ^ e[5] ^ e[7];
      code_d[1] = e[2] ^ e[3] ^ e[6] ^ e[7];
      code_d[2] = e[4] ^ e[5] ^ e[6] ^ e[7];
    end
  end

  // Population count of e. It separates e=8'h00 from e=8'h01,
  // because both of those inputs give the code 0.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ones = ones + {3'b000, e[i]};
    end
  end

  always_comb begin
    valid_d = en && (ones == 4'd1);
  end

  // The registers have no load enable and sample on every edge.
  // Reset clears them at once, so any pending update is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign s        = code_d;
  assign onehot   = valid_d;
  assign s_q      = code_q;
  assign onehot_q = valid_q;

endmodule

// File: tb/tb_codificador_8_a_3.sv
module tb_codificador_8_a_3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] e;
  logic [2:0] s;
  logic [2:0] s_q;
  logic       onehot;
  logic       onehot_q;

  int unsigned total;
  int unsigned bad;

  codificador_8_a_3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .e        (e),
    .s        (s),
    .s_q      (s_q),
    .onehot   (onehot),
    .onehot_q (onehot_q)
  );

  // Clock period is 20. Rising edges fall at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: XOR together the indices of all set bits.
  function automatic logic [2:0] model_s(input logic en_v, input logic [7:0] e_v);
    logic [2:0] r;
    r = 3'd0;
    if (en_v) begin
      for (int k = 0; k < 8; k++) begin
        if (e_v[k]) r = r ^ 3'(k);
      end
    end
    return r;
  endfunction

  function automatic logic model_oh(input logic en_v, input logic [7:0] e_v);
    int n;
    n = 0;
    for (int k = 0; k < 8; k++) n += int'(e_v[k]);
    return en_v && (n == 1);
  endfunction

  initial begin
    logic [8:0] v;
    logic [2:0] prev_s;
    logic       prev_oh;
    total = 0;
    bad   = 0;

    // Power-up: reset is low at time 0, and the combinational path is already live.
    rst_n = 1'b0;
    en    = 1'b1;
    e     = 8'h80;
    #1;
    check("pu_s",        {5'd0, s},        8'd7);
    check("pu_onehot",   {7'd0, onehot},   8'd1);
    check("pu_s_q",      {5'd0, s_q},      8'd0);
    check("pu_onehot_q", {7'd0, onehot_q}, 8'd0);
    @(posedge clk); #1;
    check("pu_hold_s_q", {5'd0, s_q},      8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("pu_rel_s_q",  {5'd0, s_q},      8'd0);
    @(posedge clk); #1;
    check("pu_cap_s_q",  {5'd0, s_q},      8'd7);
    check("pu_cap_oh_q", {7'd0, onehot_q}, 8'd1);

    // One-hot walk with en=1, then the same walk with en=0.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1;
      e  = 8'h01 << i;
      #5;
      check("walk_s",  {5'd0, s},      8'(i));
      check("walk_oh", {7'd0, onehot}, 8'd1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b0;
      e  = 8'h01 << i;
      #5;
      check("walk_dis_s",  {5'd0, s},      8'd0);
      check("walk_dis_oh", {7'd0, onehot}, 8'd0);
    end

    // Inputs that are not one-hot.
    @(negedge clk); en = 1'b1; e = 8'h06; #5;
    check("nonoh_06_s",  {5'd0, s},      8'd3);
    check("nonoh_06_oh", {7'd0, onehot}, 8'd0);
    @(negedge clk); e = 8'hFF; #5;
    check("nonoh_ff_s",  {5'd0, s},      8'd0);
    check("nonoh_ff_oh", {7'd0, onehot}, 8'd0);
    @(negedge clk); e = 8'h00; #5;
    check("zero_s",      {5'd0, s},      8'd0);
    check("zero_oh",     {7'd0, onehot}, 8'd0);
    @(negedge clk); e = 8'h01; #5;
    check("one_s",       {5'd0, s},      8'd0);
    check("one_oh",      {7'd0, onehot}, 8'd1);

    // Pipeline latency.
    @(negedge clk); en = 1'b1; e = 8'h20;
    @(posedge clk); #1;
    check("pipe_s_q_N",  {5'd0, s_q},      8'd5);
    check("pipe_oh_q_N", {7'd0, onehot_q}, 8'd1);
    e = 8'h08; #1;
    check("pipe_s_now",  {5'd0, s},        8'd3);
    check("pipe_s_q_hold", {5'd0, s_q},    8'd5);
    @(posedge clk); #1;
    check("pipe_s_q_N1", {5'd0, s_q},      8'd3);

    // Asynchronous reset asserted between clock edges.
    @(negedge clk); e = 8'h80;
    @(posedge clk); #1;
    check("ar_pre_s_q",  {5'd0, s_q},      8'd7);
    #4; rst_n = 1'b0; #1;
    check("ar_s_q",      {5'd0, s_q},      8'd0);
    check("ar_oh_q",     {7'd0, onehot_q}, 8'd0);
    e = 8'h40; #1;
    check("ar_s_live",   {5'd0, s},        8'd6);
    check("ar_oh_live",  {7'd0, onehot},   8'd1);
    @(posedge clk); #1;
    check("ar_hold_s_q", {5'd0, s_q},      8'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("ar_rel_s_q",  {5'd0, s_q},      8'd0);
    @(posedge clk); #1;
    check("ar_cap_s_q",  {5'd0, s_q},      8'd6);
    check("ar_cap_oh_q", {7'd0, onehot_q}, 8'd1);

    // Exhaustive sweep of {en,e}. The registered outputs are checked against
    // the previous vector.
    for (int n = 0; n < 512; n++) begin
      @(negedge clk);
      v  = 9'(n);
      en = v[8];
      e  = v[7:0];
      #5;
      check("sweep_s",  {5'd0, s},      {5'd0, model_s(en, e)});
      check("sweep_oh", {7'd0, onehot}, {7'd0, model_oh(en, e)});
      prev_s  = model_s(en, e);
      prev_oh = model_oh(en, e);
      @(posedge clk); #1;
      check("sweep_s_q",  {5'd0, s_q},      {5'd0, prev_s});
      check("sweep_oh_q", {7'd0, onehot_q}, {7'd0, prev_oh});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/codificador_8_a_3.md
# codificador_8_a_3

Combinational 8-to-3 binary encoder with enable, plus a one-cycle registered copy of the code and a one-hot validity flag. Each 3-bit output bit is the XOR of its four contributing input bits. One-hot inputs therefore give the conventional index code. Non-one-hot inputs give a defined parity code rather than a priority result. The block sits between a one-hot request/select source and downstream logic that needs a binary index, either immediately or pipelined.

## Interface
Parameters: none.

Ports:
- clk  input  1  single system clock; all registered outputs update on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  encoder enable; 0 forces the code to zero
- e  input  8  input vector, bit i represents index i
- s  output  3  combinational code, zero time/cycle latency from en, e
- s_q  output  3  s registered on rising clk
- onehot  output  1  combinational: en=1 and exactly one bit of e set
- onehot_q  output  1  onehot registered on rising clk

## Operation
- en=0:
  - s=3'b000, regardless of e.
  - onehot=0.
- en=1, mandatory bit equations (XOR, not OR, not priority):
  - s[0] = e[1]^e[3]^e[5]^e[7]
  - s[1] = e[2]^e[3]^e[6]^e[7]
  - s[2] = e[4]^e[5]^e[6]^e[7]
- One-hot e=1<<i gives s=i, i=0..7.
- e=8'h00 and e=8'h01 both give s=3'b000; onehot distinguishes them (0 and 1 respectively).
- Multi-bit e gives the bitwise XOR of the individual indices. This is defined behaviour, not don't-care.
  - Example: e=8'b0000_0110 gives s=3'b011.
  - Example: e=8'hFF gives s=3'b000.
- onehot = en & (popcount(e)==1).
- s and onehot are purely combinational: no latches, no dependence on clk or rst_n.
- Registered path:
  - s_q <= s and onehot_q <= onehot on every rising clk.
  - No load enable: the registers sample every cycle.

## Timing
- s and onehot are valid within combinational settle time of any change on en or e; a bench sample 10 time units after a change must see the final value.
- s_q and onehot_q have 1-cycle latency: they show the value of s/onehot sampled at the previous rising clk.
- Reset:
  - rst_n=0 immediately (asynchronously, no clock needed) forces s_q=3'b000 and onehot_q=0.
  - They are held while rst_n=0.
  - The first capture is on the first rising clk after rst_n returns to 1.
- Reset never affects s or onehot; the combinational path stays live during reset.
- Reset asserted mid-stream clears s_q/onehot_q at once; the captured value is lost, and no pending update survives.
- Input change coincident with a clk edge: the registers capture the pre-edge settled value (standard setup requirement).

## Test plan
- Exhaustive sweep of {en,e} over 0..511, 10 time units per step -> s matches the XOR equations for en=1 and 3'b000 for en=0. Error count must be 0.
- One-hot walk with en=1, e=8'h01,02,04,...,80 -> s=0,1,...,7 and onehot=1 each step. Same walk with en=0 -> s=0, onehot=0.
- Non-one-hot with en=1:
  - e=8'h06 -> s=3'b011, onehot=0.
  - e=8'hFF -> s=3'b000, onehot=0.
  - e=8'h00 -> s=3'b000, onehot=0.
- Pipeline check: drive e=8'h20, en=1 before edge N -> s_q=3'b101 and onehot_q=1 after edge N. Change e=8'h08 -> s=3 immediately, while s_q stays 5 until edge N+1.
- Async reset: with s_q=3'b111, drop rst_n between clock edges -> s_q=0 and onehot_q=0 with no clock edge, while s still tracks e. Release rst_n -> capture resumes at the next rising edge.
- Power-up: rst_n low at time 0 with e=8'h80, en=1 -> s=3'b111 combinationally, s_q=0 until the first edge after release.
